// File: rtl/conv3x3_sched.sv
// conv3x3_sched: holds 3x3 kernel weights and walks a sliding window over a RAM image for a conv datapath
module conv3x3_sched #(
  parameter int DW = 16,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            w_we,
  input  logic [3:0]      w_idx,
  input  logic [DW-1:0]   w_data,
  output logic            mem_rd_en,
  output logic [AW-1:0]   mem_rd_addr,
  input  logic [DW-1:0]   mem_rd_data,
  output logic [9*DW-1:0] win,
  output logic [9*DW-1:0] wgt,
  input  logic [DW-1:0]   conv_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [AW-1:0]   out_addr,
  output logic            busy,
  output logic            done
);
  typedef enum logic [2:0] {IDLE, FILL, SLIDE, DRAIN, CALC, EMIT, DONE} state_t;
  state_t state, nxt;
  logic [AW-1:0] r, c;
  logic [1:0] kr, kc;
  logic cap, last_col, last_row, fill_end;
  logic [DW-1:0] px [9];
  logic [DW-1:0] w [9];
  always_comb begin
    last_col = c == AW'(IMG_W - 3);
    last_row = r == AW'(IMG_H - 3);
    fill_end = kr == 2'd2 && kc == 2'd2;
    nxt = state;
    case (state)
      IDLE:  nxt = start ? FILL : IDLE;
      FILL:  nxt = fill_end ? DRAIN : FILL;
      SLIDE: nxt = kr == 2'd2 ? DRAIN : SLIDE;
      DRAIN: nxt = CALC;
      CALC:  nxt = EMIT;
      EMIT:  nxt = !out_ready ? EMIT : last_col && last_row ? DONE : last_col ? FILL : SLIDE;
      default: nxt = IDLE;
    endcase
    mem_rd_en = state == FILL || state == SLIDE;
    mem_rd_addr = mem_rd_en ? (r + AW'(kr)) * AW'(IMG_W) + c + AW'(kc) : '0;
    out_valid = state == EMIT;
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // px is a column-major shift chain: every returned read shifts in at px[8],
  // so 9 fills load a whole window and 3 slides move it one column left
  always_ff @(posedge clk) begin
    if (rst) begin
      {r, c, kr, kc, cap, out_data, out_addr} <= '0;
      for (int i = 0; i < 9; i++) begin
        px[i] <= '0;
        w[i] <= '0;
      end
    end else begin
      cap <= mem_rd_en;
      if (cap) begin
        for (int i = 0; i < 8; i++) px[i] <= px[i+1];
        px[8] <= mem_rd_data;
      end
      if (state == IDLE && w_we && w_idx < 4'd9) w[w_idx] <= w_data;
      if (state == IDLE && start) {r, c, kr, kc} <= '0;
      if (state == FILL) begin
        kr <= kr == 2'd2 ? 2'd0 : kr + 2'd1;
        kc <= kc + {1'b0, kr == 2'd2};
      end
      if (state == SLIDE) kr <= kr + 2'd1;
      if (state == CALC) begin
        out_data <= conv_result;
        out_addr <= r * AW'(IMG_W - 2) + c;
      end
      if (state == EMIT && out_ready) begin
        r <= last_col ? (last_row ? '0 : r + AW'(1)) : r;
        c <= last_col ? '0 : c + AW'(1);
        kr <= 2'd0;
        kc <= last_col ? 2'd0 : 2'd2;
      end
    end
  end
  for (genvar k = 0; k < 9; k++) begin : g
    assign win[k*DW +: DW] = px[(k%3)*3 + k/3];
    assign wgt[k*DW +: DW] = w[k];
  end
endmodule

// File: tb/tb_conv3x3_sched.sv
// tb_conv3x3_sched: runs a 28x28 and a 4x4 sequencer side by side against a sum-of-products image model
module tb_conv3x3_sched;
  logic clk = 0, rst = 1, start = 0, w_we = 0, out_ready = 1;
  logic [3:0] w_idx = 0;
  logic [15:0] w_data = 0;
  always #5 clk = ~clk;

  logic rd_en28, ov28, busy28, done28, rd_en4, ov4, busy4, done4;
  logic [9:0] rd_addr28, oa28;
  logic [3:0] rd_addr4, oa4;
  logic [15:0] rd_data28, conv28, od28, rd_data4, conv4, od4;
  logic [143:0] win28, wgt28, win4, wgt4;

  conv3x3_sched #(.DW(16), .IMG_W(28), .IMG_H(28), .AW(10)) u28 (
    .clk(clk), .rst(rst), .start(start), .w_we(w_we), .w_idx(w_idx), .w_data(w_data),
    .mem_rd_en(rd_en28), .mem_rd_addr(rd_addr28), .mem_rd_data(rd_data28),
    .win(win28), .wgt(wgt28), .conv_result(conv28),
    .out_valid(ov28), .out_ready(out_ready), .out_data(od28), .out_addr(oa28),
    .busy(busy28), .done(done28));
  conv3x3_sched #(.DW(16), .IMG_W(4), .IMG_H(4), .AW(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .w_we(w_we), .w_idx(w_idx), .w_data(w_data),
    .mem_rd_en(rd_en4), .mem_rd_addr(rd_addr4), .mem_rd_data(rd_data4),
    .win(win4), .wgt(wgt4), .conv_result(conv4),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_addr(oa4),
    .busy(busy4), .done(done4));

  logic [15:0] ram28 [784];
  logic [15:0] ram4 [16];
  always @(posedge clk) if (rd_en28) rd_data28 <= ram28[rd_addr28];
  always @(posedge clk) if (rd_en4) rd_data4 <= ram4[rd_addr4];

  function automatic logic [15:0] dp(input logic [143:0] wi, input logic [143:0] wg);
    logic [15:0] s = 0;
    for (int k = 0; k < 9; k++) s += wi[k*16 +: 16] * wg[k*16 +: 16];
    return s;
  endfunction
  assign conv28 = dp(win28, wgt28);
  assign conv4 = dp(win4, wgt4);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int qa28[$], qd28[$], qa4[$], qd4[$];
  int nrd28 = 0, nrd4 = 0, nd28 = 0, nd4 = 0, dc28 = 0, dc4 = 0;
  always @(negedge clk) begin
    #2;
    if (ov28 && out_ready) begin qa28.push_back(int'(oa28)); qd28.push_back(int'(od28)); end
    if (ov4 && out_ready) begin qa4.push_back(int'(oa4)); qd4.push_back(int'(od4)); end
    if (rd_en28) nrd28++;
    if (rd_en4) nrd4++;
    if (done28) begin nd28++; dc28 = cyc; end
    if (done4) begin nd4++; dc4 = cyc; end
  end

  logic [15:0] wm [9];
  int n_cmp = 0, n_bad = 0;
  int t0, b_q28, b_q4, b_rd28, b_rd4, b_d28, b_d4;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] pack_w();
    logic [143:0] p;
    for (int k = 0; k < 9; k++) p[k*16 +: 16] = wm[k];
    return p;
  endfunction

  function automatic logic [15:0] pix(input bit big, input int a);
    return big ? ram28[a] : ram4[a];
  endfunction

  function automatic logic [15:0] ref_out(input bit big, input int r, input int c);
    int wd = big ? 28 : 4;
    logic [15:0] s = 0;
    for (int k = 0; k < 9; k++) s += wm[k] * pix(big, (r + k/3) * wd + c + k%3);
    return s;
  endfunction

  task automatic set_w(input logic [3:0] idx, input logic [15:0] v);
    w_we = 1; w_idx = idx; w_data = v;
    if (idx < 9) wm[idx] = v;
    tick;
    w_we = 0;
    chk("wgt28", wgt28, pack_w());
    chk("wgt4", wgt4, pack_w());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_win28"}, win28, 0);
    chk({tag, "_wgt28"}, wgt28, 0);
    chk({tag, "_out28"}, {rd_en28, rd_addr28, ov28, od28, oa28, busy28, done28}, 0);
    chk({tag, "_win4"}, win4, 0);
    chk({tag, "_wgt4"}, wgt4, 0);
    chk({tag, "_out4"}, {rd_en4, rd_addr4, ov4, od4, oa4, busy4, done4}, 0);
  endtask

  task automatic start_frame(input bit with_w, input logic [15:0] wv);
    b_q28 = qa28.size(); b_q4 = qa4.size();
    b_rd28 = nrd28; b_rd4 = nrd4; b_d28 = nd28; b_d4 = nd4;
    start = 1;
    if (with_w) begin w_we = 1; w_idx = 0; w_data = wv; wm[0] = wv; end
    tick;
    t0 = cyc; start = 0; w_we = 0;
    chk("busy_cycle1", {busy28, busy4}, 2'b11);
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!ov28 && n < 40) begin tick; n++; end
    chk("first_valid_cycle", cyc - t0 + 1, 12);
    chk("first_valid4", ov4, 1);
  endtask

  task automatic cmp_outputs(input bit big);
    int wd = big ? 28 : 4;
    int base = big ? b_q28 : b_q4;
    int n = (big ? qa28.size() : qa4.size()) - base;
    int i = base;
    chk(big ? "count28" : "count4", n, (wd - 2) * (wd - 2));
    for (int r = 0; r < wd - 2; r++)
      for (int c = 0; c < wd - 2; c++) begin
        if (i < base + n) begin
          if (big) begin
            chk($sformatf("addr28[%0d]", i - base), qa28[i], r * (wd - 2) + c);
            chk($sformatf("data28[%0d]", i - base), qd28[i], ref_out(1, r, c));
          end else begin
            chk($sformatf("addr4[%0d]", i - base), qa4[i], r * (wd - 2) + c);
            chk($sformatf("data4[%0d]", i - base), qd4[i], ref_out(0, r, c));
          end
        end
        i++;
      end
  endtask

  task automatic finish_frame(input int extra);
    int n = 0;
    while (nd28 == b_d28 && n < 6000) begin tick; n++; end
    tick; tick;
    chk("done28_count", nd28 - b_d28, 1);
    chk("done28_cycle", dc28 - t0 + 1, 4213 + extra);
    chk("done4_count", nd4 - b_d4, 1);
    chk("done4_cycle", dc4 - t0 + 1, 37 + extra);
    chk("reads28", nrd28 - b_rd28, 26 * (9 + 25 * 3));
    chk("reads4", nrd4 - b_rd4, 24);
    chk("busy_after", {busy28, busy4, ov28, ov4}, 0);
    cmp_outputs(1);
    cmp_outputs(0);
  endtask

  initial begin
    logic [143:0] ew;
    for (int a = 0; a < 784; a++) ram28[a] = 16'(a);
    for (int a = 0; a < 16; a++) ram4[a] = 16'(a);
    for (int k = 0; k < 9; k++) wm[k] = 0;
    tick; tick;
    chk_zero("in_reset");
    rst = 0;
    tick;
    chk_zero("after_reset");

    for (int k = 0; k < 9; k++) set_w(4'(k), 16'd1);
    start_frame(0, 0);
    wait_valid;
    chk("first_data28", od28, 261);
    chk("first_addr28", oa28, 0);
    finish_frame(0);
    chk("second_data28", qd28[b_q28 + 1], 270);
    chk("second_addr28", qa28[b_q28 + 1], 1);

    for (int k = 0; k < 9; k++) set_w(4'(k), 16'(k + 1));
    for (int k = 0; k < 9; k++) ew[k*16 +: 16] = ram4[(k/3) * 4 + k%3];
    out_ready = 0;
    start_frame(0, 0);
    wait_valid;
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", {ov28, ov4}, 2'b11);
      chk("stall_data4", od4, ref_out(0, 0, 0));
      chk("stall_addr4", oa4, 0);
      chk("stall_win4", win4, ew);
      chk("stall_noread", {rd_en28, rd_en4}, 0);
      tick;
    end
    out_ready = 1;
    tick;
    chk("resume_read4", rd_en4, 1);
    chk("resume_valid4", ov4, 0);
    finish_frame(20);

    for (int a = 0; a < 784; a++) ram28[a] = 16'($urandom);
    for (int a = 0; a < 16; a++) ram4[a] = 16'($urandom);
    for (int k = 0; k < 9; k++) set_w(4'(k), 16'($urandom));
    start_frame(0, 0);
    for (int i = 0; i < 28; i++) begin
      start = 1'($urandom_range(0, 1));
      w_we = 1'($urandom_range(0, 1));
      w_idx = 4'($urandom_range(0, 15));
      w_data = 16'($urandom);
      tick;
      chk("wgt_busy28", wgt28, pack_w());
      chk("wgt_busy4", wgt4, pack_w());
    end
    start = 0; w_we = 0;
    finish_frame(0);

    for (int a = 0; a < 784; a++) ram28[a] = 16'(a);
    for (int a = 0; a < 16; a++) ram4[a] = 16'(a);
    for (int k = 0; k < 9; k++) set_w(4'(k), 16'd1);
    start_frame(0, 0);
    wait_valid;
    tick; tick;
    chk("in_slide28", {rd_en28, ov28}, 2'b10);
    rst = 1;
    tick;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    chk_zero("mid_reset");
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("post_reset_idle", {rd_en28, rd_en4, ov28, ov4, busy28, busy4}, 0);
    end
    for (int k = 0; k < 9; k++) set_w(4'(k), 16'd1);
    start_frame(0, 0);
    wait_valid;
    chk("rerun_data28", od28, 261);
    finish_frame(0);
    chk("rerun_second28", qd28[b_q28 + 1], 270);

    set_w(4'd12, 16'hBEEF);
    for (int a = 0; a < 784; a++) ram28[a] = 16'($urandom);
    for (int a = 0; a < 16; a++) ram4[a] = 16'($urandom);
    start_frame(1, 16'd5);
    chk("same_cycle_w0", wgt28[15:0], 5);
    wait_valid;
    chk("same_cycle_data28", od28, ref_out(1, 0, 0));
    chk("same_cycle_data4", od4, ref_out(0, 0, 0));
    finish_frame(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
